usrt_tx_queue: RTL

Host-side transmit queue placed directly upstream of the USRT transmitter. It accepts bytes from the host at full clock rate into a small circular FIFO. It then drains them one at a time: it presents each byte on a stable data bus, issues a one-cycle SEND pulse, and waits for the transmitter's active-low completion interrupt (NINTO) before releasing the next byte. It replaces the single-byte load buffer on the transmit path, so the host no longer has to poll completion between bytes.

---
 rtl/usrt_pkg.sv | 15 +
 rtl/usrt_tx_queue_if.sv | 32 +++
 rtl/usrt_fifo_mem.sv | 74 +++++++
 rtl/usrt_tx_queue.sv | 94 +++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT transmit-queue slice: FSM encoding and default geometry.
package usrt_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE,
    WAIT_REL
  } tx_state_e;

endpackage

// File: rtl/usrt_tx_queue_if.sv
// Host/transmitter-facing signal bundle of the transmit queue.
interface usrt_tx_queue_if #(
  parameter int unsigned DEPTH = usrt_pkg::DEFAULT_DEPTH,
  parameter int unsigned WIDTH = usrt_pkg::DEFAULT_WIDTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             WR;
  logic [WIDTH-1:0] Host_Data;
  logic             Clr_Ovf;
  logic             Full;
  logic             Empty;
  logic [AW:0]      Count;
  logic             Overflow;
  logic [WIDTH-1:0] Data_Out;
  logic             SEND;
  logic             NINTO;
  logic             Busy;

  // Host and transmitter side (drives writes and the completion interrupt).
  modport master (
    output WR, Host_Data, Clr_Ovf, NINTO,
    input  Full, Empty, Count, Overflow, Data_Out, SEND, Busy
  );

  // Queue side.
  modport slave (
    input  WR, Host_Data, Clr_Ovf, NINTO,
    output Full, Empty, Count, Overflow, Data_Out, SEND, Busy
  );

endinterface

// File: rtl/usrt_fifo_mem.sv
// Circular register FIFO with occupancy counter; push/pop are plain strobes gated by full/empty.
module usrt_fifo_mem
  import usrt_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags come from the post-update count so they stay registered outputs.
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end

  assign rdata = mem_q[rp_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/usrt_tx_queue.sv
// Transmit queue: buffers host bytes and hands them to the USRT one at a time,
// pulsing SEND and waiting for the active-low completion interrupt between bytes.
module usrt_tx_queue
  import usrt_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            Clock,
  input  logic            Reset,
  usrt_tx_queue_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             send_q, send_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic             pop;
  logic [WIDTH-1:0] rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  usrt_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (bus.WR),
    .wdata (bus.Host_Data),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stale low NINTO blocks the start of a new byte.
        if (!fifo_empty && bus.NINTO) begin
          state_d = LOAD;
          pop     = 1'b1;
        end
      end
      LOAD:      state_d = SEND;
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.NINTO) state_d = WAIT_REL;
      WAIT_REL:  if (bus.NINTO)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    data_d = pop ? rdata : data_q;
    // SEND and Busy are decoded from the next state so they are flop outputs.
    send_d = (state_d == SEND);
    busy_d = (state_d != IDLE);

    ovf_d = ovf_q;
    if (bus.Clr_Ovf)            ovf_d = 1'b0;
    if (bus.WR && fifo_full)    ovf_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Full     = fifo_full;
  assign bus.Empty    = fifo_empty;
  assign bus.Count    = fifo_count;
  assign bus.Overflow = ovf_q;
  assign bus.Data_Out = data_q;
  assign bus.SEND     = send_q;
  assign bus.Busy     = busy_q;

endmodule
